// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and the
// even-parity helper used when a parity bit is on the line.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_sync (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, mid-bit sampling of data,
// optional even parity and stop bit, byte delivered with a one-clock valid.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter bit PARITY_EN = 1'b0,
    parameter int OS_RATE   = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       os_stb,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int            CW       = $clog2(OS_RATE);
    localparam logic [CW-1:0] MID_CNT  = CW'(OS_RATE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OS_RATE - 1);

    logic w_rxs;

    uart_state_e   r_state,   w_state_nxt;
    logic [CW-1:0] r_os_cnt,  w_os_cnt_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]    r_shreg,   w_shreg_nxt;
    logic          r_par_bad, w_par_bad_nxt;
    logic          r_armed,   w_armed_nxt;
    logic          w_stop_hit;

    logic          r_stop_hit;
    logic          r_stop_bit;
    logic [7:0]    r_dout;
    logic          r_dout_vld;
    logic          r_frame_err;
    logic          r_parity_err;

    uart_sync u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (rxd),
        .o_sync  (w_rxs)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_par_bad <= 1'b0;
            r_armed   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_par_bad <= w_par_bad_nxt;
            r_armed   <= w_armed_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_os_cnt_nxt  = r_os_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_par_bad_nxt = r_par_bad;
        w_armed_nxt   = r_armed;
        w_stop_hit    = 1'b0;

        if (os_stb) begin
            case (r_state)
                IDLE: begin
                    if (w_rxs) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt   = START;
                        w_os_cnt_nxt  = '0;
                        w_par_bad_nxt = 1'b0;
                    end
                end
                START: begin
                    // A start bit that is high again at its midpoint was a glitch
                    if (r_os_cnt == MID_CNT) begin
                        w_os_cnt_nxt = '0;
                        w_state_nxt  = w_rxs ? IDLE : DATA;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_os_cnt == LAST_CNT) begin
                        w_shreg_nxt[r_bit_cnt] = w_rxs;
                        w_os_cnt_nxt           = '0;
                        if (r_bit_cnt == 3'd7) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = PARITY_EN ? PARITY : STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (r_os_cnt == LAST_CNT) begin
                        w_par_bad_nxt = w_rxs ^ even_parity(r_shreg);
                        w_os_cnt_nxt  = '0;
                        w_state_nxt   = STOP;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leave mid stop bit; a low stop disarms until the line recovers
                    if (r_os_cnt == LAST_CNT) begin
                        w_stop_hit   = 1'b1;
                        w_armed_nxt  = w_rxs;
                        w_os_cnt_nxt = '0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_os_cnt_nxt  = '0;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stop_hit   <= 1'b0;
            r_stop_bit   <= 1'b1;
            r_dout       <= '0;
            r_dout_vld   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_stop_hit <= w_stop_hit;
            if (w_stop_hit) begin
                r_stop_bit <= w_rxs;
            end
            r_dout_vld <= r_stop_hit;
            if (r_stop_hit) begin
                r_dout       <= r_shreg;
                r_frame_err  <= ~r_stop_bit;
                r_parity_err <= PARITY_EN & r_par_bad;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_vld   = r_dout_vld;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one receiver without parity, one with
// even parity, driven with directed and random frames against a frame model.
module tb_uart_rx;

    localparam int OS          = 16;
    localparam int CLK_PER_STB = 4;
    localparam int BIT_CLKS    = OS * CLK_PER_STB;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         stb;
    } rxRec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       osStb = 1'b0;
    logic       rxd0, rxd1;
    logic [7:0] dout0, dout1;
    logic       vld0, vld1, fe0, fe1, pe0, pe1;

    int compared   = 0;
    int mismatched = 0;
    int stbCount   = 0;
    int stbPhase   = 0;
    int run0 = 0, run1 = 0, maxRun0 = 0, maxRun1 = 0;
    bit sawPe0 = 1'b0;

    rxRec_t capQ0[$], capQ1[$], expQ0[$], expQ1[$];
    rxRec_t recTmp;

    uart_rx #(.PARITY_EN(1'b0), .OS_RATE(OS)) dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .os_stb     (osStb),
        .rxd        (rxd0),
        .dout       (dout0),
        .dout_vld   (vld0),
        .frame_err  (fe0),
        .parity_err (pe0)
    );

    uart_rx #(.PARITY_EN(1'b1), .OS_RATE(OS)) dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .os_stb     (osStb),
        .rxd        (rxd1),
        .dout       (dout1),
        .dout_vld   (vld1),
        .frame_err  (fe1),
        .parity_err (pe1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        stbPhase = (stbPhase + 1) % CLK_PER_STB;
        osStb    = (stbPhase == 0);
        if (osStb) stbCount++;
    end

    // Record every delivered byte and track the width of each valid pulse
    always @(negedge clk) begin
        if (vld0) begin
            recTmp.d = dout0; recTmp.fe = fe0; recTmp.pe = pe0; recTmp.stb = stbCount;
            capQ0.push_back(recTmp);
            run0++;
        end else begin
            run0 = 0;
        end
        if (vld1) begin
            recTmp.d = dout1; recTmp.fe = fe1; recTmp.pe = pe1; recTmp.stb = stbCount;
            capQ1.push_back(recTmp);
            run1++;
        end else begin
            run1 = 0;
        end
        if (run0 > maxRun0) maxRun0 = run0;
        if (run1 > maxRun1) maxRun1 = run1;
        if (pe0) sawPe0 = 1'b1;
    end

    function automatic rxRec_t refModel(input logic [7:0] data, input bit withPar,
                                        input logic parBit, input logic stopBit);
        rxRec_t r;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += data[i];
        r.d   = data;
        r.fe  = (stopBit == 1'b0);
        r.pe  = withPar && (parBit != ((ones % 2) == 1));
        r.stb = 0;
        return r;
    endfunction

    task automatic driveLine(input bit sel, input logic v, input int clks);
        if (sel) rxd1 = v; else rxd0 = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic idleLine(input bit sel, input int bits);
        driveLine(sel, 1'b1, bits * BIT_CLKS);
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit withPar,
                                 input logic parBit, input logic stopBit);
        if (sel) expQ1.push_back(refModel(data, withPar, parBit, stopBit));
        else     expQ0.push_back(refModel(data, withPar, parBit, stopBit));
        driveLine(sel, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) driveLine(sel, data[i], BIT_CLKS);
        if (withPar) driveLine(sel, parBit, BIT_CLKS);
        driveLine(sel, stopBit, BIT_CLKS);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFrames(input bit sel, input string tag);
        rxRec_t cq[$], eq[$];
        int n;
        if (sel) begin
            cq = capQ1; eq = expQ1; capQ1.delete(); expQ1.delete();
        end else begin
            cq = capQ0; eq = expQ0; capQ0.delete(); expQ0.delete();
        end
        checkOutput({tag, " frame count"}, cq.size(), eq.size());
        n = (cq.size() < eq.size()) ? cq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d] dout", tag, i), cq[i].d, eq[i].d);
            checkOutput($sformatf("%s[%0d] frame_err", tag, i), cq[i].fe, eq[i].fe);
            checkOutput($sformatf("%s[%0d] parity_err", tag, i), cq[i].pe, eq[i].pe);
        end
    endtask

    initial begin
        int         gap;
        logic [7:0] data;
        logic       stopBit;
        logic       parBit;

        rstn = 1'b0;
        rxd0 = 1'b1;
        rxd1 = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset dout0", dout0, 8'h00);
        checkOutput("reset vld0", vld0, 1'b0);
        checkOutput("reset fe0", fe0, 1'b0);
        checkOutput("reset pe0", pe0, 1'b0);
        checkOutput("reset dout1", dout1, 8'h00);
        checkOutput("reset vld1", vld1, 1'b0);
        rstn = 1'b1;
        idleLine(0, 2);

        $display("[TB] single frame 0x55");
        applyStimulus(0, 8'h55, 0, 1'b0, 1'b1);
        idleLine(0, 2);
        checkFrames(0, "t1");

        $display("[TB] back-to-back 0xA3, 0x0F");
        applyStimulus(0, 8'hA3, 0, 1'b0, 1'b1);
        applyStimulus(0, 8'h0F, 0, 1'b0, 1'b1);
        idleLine(0, 2);
        gap = (capQ0.size() >= 2) ? (capQ0[1].stb - capQ0[0].stb) : -1;
        checkOutput("t2 pulse spacing in 156..164", (gap >= 156 && gap <= 164), 1'b1);
        checkFrames(0, "t2");

        $display("[TB] start glitch then 0x81");
        driveLine(0, 1'b0, 3 * CLK_PER_STB);
        idleLine(0, 2);
        checkFrames(0, "t3 glitch");
        applyStimulus(0, 8'h81, 0, 1'b0, 1'b1);
        idleLine(0, 2);
        checkFrames(0, "t3");

        $display("[TB] framing error, break, then 0x11");
        applyStimulus(0, 8'h3C, 0, 1'b0, 1'b0);
        driveLine(0, 1'b0, 20 * BIT_CLKS);
        idleLine(0, 2);
        applyStimulus(0, 8'h11, 0, 1'b0, 1'b1);
        idleLine(0, 2);
        checkFrames(0, "t4");

        $display("[TB] parity good then bad");
        applyStimulus(1, 8'h07, 1, 1'b1, 1'b1);
        idleLine(1, 2);
        applyStimulus(1, 8'h07, 1, 1'b0, 1'b1);
        idleLine(1, 2);
        checkFrames(1, "t5");

        $display("[TB] reset mid-frame then 0x42");
        driveLine(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) driveLine(0, 1'b1, BIT_CLKS);
        driveLine(0, 1'b1, BIT_CLKS / 2);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6 reset dout", dout0, 8'h00);
        checkOutput("t6 reset vld", vld0, 1'b0);
        checkOutput("t6 reset fe", fe0, 1'b0);
        checkOutput("t6 reset pe", pe0, 1'b0);
        rstn = 1'b1;
        idleLine(0, 2);
        checkFrames(0, "t6 aborted");
        applyStimulus(0, 8'h42, 0, 1'b0, 1'b1);
        idleLine(0, 2);
        checkFrames(0, "t6");

        $display("[TB] random frames, no parity");
        for (int k = 0; k < 8; k++) begin
            data    = 8'($urandom_range(0, 255));
            stopBit = ($urandom_range(0, 3) != 0);
            applyStimulus(0, data, 0, 1'b0, stopBit);
            if (!stopBit || $urandom_range(0, 1) == 1) idleLine(0, $urandom_range(1, 2));
        end
        idleLine(0, 2);
        checkFrames(0, "rnd0");

        $display("[TB] random frames, even parity");
        for (int k = 0; k < 8; k++) begin
            data   = 8'($urandom_range(0, 255));
            parBit = (^data) ^ ($urandom_range(0, 2) == 0);
            applyStimulus(1, data, 1, parBit, 1'b1);
            if ($urandom_range(0, 1) == 1) idleLine(1, 1);
        end
        idleLine(1, 2);
        checkFrames(1, "rnd1");

        checkOutput("no-parity dut parity_err ever high", sawPe0, 1'b0);
        checkOutput("dut0 valid pulse width", maxRun0, 1);
        checkOutput("dut1 valid pulse width", maxRun1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive stage of the UART: consumes the serial line driven by the team's transmitter and recovers the byte.
- Oversamples rxd using a strobe from the baud generator, at OS_RATE strobes per bit.
- Emits each byte with a one-cycle valid pulse, plus frame-error and parity-error flags.
- Sits directly downstream of uart_tx, or of an external pin, and feeds the host-side byte sink.

Parameters:
PARITY_EN, 0, 1 = expect an even-parity bit between the last data bit and the stop bit; 0 = no parity bit.
OS_RATE, 16, os_stb pulses per bit period; must be even and at least 8.

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
os_stb  input  1  oversample strobe, one clk wide, OS_RATE per bit
rxd  input  1  serial line, idle high, asynchronous to clk
dout  output  8  received byte, LSB first on the line; held until the next frame completes
dout_vld  output  1  one-clk pulse when a frame completes
frame_err  output  1  valid with dout_vld: stop bit sampled 0
parity_err  output  1  valid with dout_vld: parity mismatch; always 0 when PARITY_EN=0

Behaviour:
- Reset values: dout=0, dout_vld=0, frame_err=0, parity_err=0, FSM=IDLE, counters=0, sync flops=1, armed=1.
- Reset is honoured mid-frame; any partial byte is discarded and no dout_vld is produced.
- rxd passes through a 2-flop synchronizer (rxs); all decisions use rxs.
- FSM and counters advance only on clks with os_stb=1. The one exception: the dout_vld/flag registers load on the clk after the stop sample.
- Counters: os_cnt counts 0..OS_RATE-1; bit_cnt counts 0..7.
- IDLE:
  - If rxs=1, set armed=1.
  - If armed and rxs=0 on an os_stb, go to START with os_cnt=0.
- START:
  - At os_cnt=OS_RATE/2-1 (mid start bit), resample.
  - If rxs=1, it is a glitch: go to IDLE with no output.
  - Otherwise clear os_cnt and go to DATA.
- DATA:
  - Sample at os_cnt=OS_RATE-1, which is mid-bit relative to the start sample.
  - Shift into shreg[bit_cnt]; bit_cnt increments.
  - After bit 7, go to PARITY if PARITY_EN, else STOP; bit_cnt wraps to 0.
- PARITY: sample as in DATA; par_bad = sample XOR (^shreg). Go to STOP.
- STOP: sample as in DATA, then go to IDLE immediately.
  - This is still mid stop bit, so back-to-back frames with a 0.5-bit stop margin are accepted.
  - On the next clk: dout<=shreg, dout_vld=1 for exactly 1 clk, frame_err=~sample, parity_err=par_bad.
  - frame_err and parity_err hold their value until the next dout_vld.
- Frame error (stop=0, break): still deliver the byte with frame_err=1. Set armed=0 so no start is detected until rxs is seen high.
- Latency: dout_vld rises 1 clk after the os_stb that samples stop, i.e. about 3 clk after rxd reaches the synchronizer input at mid stop bit.
- os_stb held low freezes the FSM; rxd changes are not observed by the FSM while frozen.
- No backpressure. The consumer must accept dout_vld when it pulses; dout is overwritten by the next frame.

Decomposition:
- Shared package/header uart_defs: FSM state constants IDLE/START/DATA/PARITY/STOP (3-bit), and a parity helper function (even parity = XOR of data).
- Reuse the same constants in uart_tx.
- One sub-module, uart_sync: 2-flop synchronizer, reset value 1, async active-low reset.

Test Plan:
1. OS_RATE=16, os_stb every 4 clk. Drive frame 0x55 (start, 10101010 LSB-first, stop=1) -> one dout_vld pulse with dout=0x55, frame_err=0, parity_err=0.
2. Back-to-back frames 0xA3 then 0x0F with no idle gap -> two dout_vld pulses 160±4 os_stb apart, values 0xA3 and 0x0F in order.
3. 3-os_stb low glitch on idle line -> FSM returns to IDLE, no dout_vld. A following valid 0x81 frame is received correctly.
4. Frame 0x3C with stop bit driven 0, line held low for 20 bit times, then 0x11 -> dout=0x3C with frame_err=1, no spurious frames during the low period, then 0x11 with frame_err=0.
5. PARITY_EN=1, frames 0x07 with parity 1 and 0x07 with parity 0 -> parity_err=0, then parity_err=1. PARITY_EN=0 -> parity_err never asserts.
6. Assert rstn low during bit 4 of 0xFF, release, then send 0x42 -> no output for the aborted frame; all outputs at reset values; dout=0x42 received cleanly.
